// File: rtl/vm2002_coin_acceptor.sv
// Coin front-end for the vm2002 vending core: session window, credit accumulation, offer/refund.
// Optional per-denomination statistics are built when VM2002_COIN_STATS_EN is defined.
module vm2002_coin_acceptor #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CREDIT_W       = 10,
  parameter int MAX_CREDIT     = 500
) (
  input  logic                clk,
  input  logic                hrst_n,
  input  logic                srst,
  input  logic                insert_coins,
  input  logic                coin_valid,
  input  logic [1:0]          coin,
  input  logic                select,
  output logic                coin_ack,
  output logic                coin_reject,
  output logic                start_timer,
  output logic                timeout,
  output logic [CREDIT_W-1:0] credit,
  output logic                credit_valid,
  input  logic                credit_ready,
  output logic                refund_valid,
  output logic [CREDIT_W-1:0] refund_amount,
  output logic [31:0]         coin_stats
);

  // state   | meaning
  // IDLE    | no session, coins returned, credit shown as 0
  // COLLECT | window running, coins accumulate
  // OFFER   | final credit offered to the core, timer frozen
  // REFUND  | one-cycle refund strobe, then back to IDLE
  typedef enum logic [1:0] {IDLE, COLLECT, OFFER, REFUND} state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef logic [CREDIT_W:0] sum_t;
  typedef logic [TW-1:0]     timer_t;

  state_t state;
  timer_t timer;
  sum_t   coin_value;
  sum_t   credit_sum;
  logic   fits;
  logic   coin_take;

  // The extra sum bit keeps the ceiling compare from wrapping.
  always_comb begin
    coin_value = '0;
    unique case (coin)
      2'd0: coin_value = sum_t'(5);
      2'd1: coin_value = sum_t'(10);
      2'd2: coin_value = sum_t'(25);
      2'd3: coin_value = sum_t'(100);
    endcase
    credit_sum = {1'b0, credit} + coin_value;
    fits       = credit_sum <= sum_t'(MAX_CREDIT);
    coin_take  = (state == COLLECT) && !srst && coin_valid && fits;
  end

  always_ff @(posedge clk) begin
    if (!hrst_n) begin
      state         <= IDLE;
      timer         <= '0;
      credit        <= '0;
      coin_ack      <= 1'b0;
      coin_reject   <= 1'b0;
      start_timer   <= 1'b0;
      timeout       <= 1'b0;
      credit_valid  <= 1'b0;
      refund_valid  <= 1'b0;
      refund_amount <= '0;
    end else begin
      coin_ack    <= 1'b0;
      coin_reject <= 1'b0;
      timeout     <= 1'b0;
      unique case (state)
        IDLE: begin
          credit      <= '0;
          coin_reject <= coin_valid;
          if (insert_coins) begin
            state       <= COLLECT;
            timer       <= timer_t'(TIMEOUT_CYCLES);
            start_timer <= 1'b1;
          end
        end
        COLLECT: begin
          if (srst) begin
            coin_reject <= coin_valid;
            start_timer <= 1'b0;
            if (credit != '0) begin
              state         <= REFUND;
              refund_valid  <= 1'b1;
              refund_amount <= credit;
            end else begin
              state <= IDLE;
            end
          end else begin
            if (coin_take) begin
              credit   <= credit_sum[CREDIT_W-1:0];
              coin_ack <= 1'b1;
              timer    <= timer_t'(TIMEOUT_CYCLES);
            end else begin
              coin_reject <= coin_valid;
              if (timer != '0) timer <= timer - timer_t'(1);
            end
            if (select) begin
              state        <= OFFER;
              start_timer  <= 1'b0;
              credit_valid <= 1'b1;
            end else if (!coin_take && timer == '0) begin
              timeout     <= 1'b1;
              start_timer <= 1'b0;
              if (credit != '0) begin
                state         <= REFUND;
                refund_valid  <= 1'b1;
                refund_amount <= credit;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        OFFER: begin
          coin_reject <= coin_valid;
          if (credit_ready) begin
            credit_valid <= 1'b0;
            credit       <= '0;
            state        <= IDLE;
          end else if (srst) begin
            credit_valid <= 1'b0;
            if (credit != '0) begin
              state         <= REFUND;
              refund_valid  <= 1'b1;
              refund_amount <= credit;
            end else begin
              state <= IDLE;
            end
          end
        end
        REFUND: begin
          coin_reject   <= coin_valid;
          refund_valid  <= 1'b0;
          refund_amount <= '0;
          credit        <= '0;
          state         <= IDLE;
        end
      endcase
    end
  end

`ifdef VM2002_COIN_STATS_EN
  logic [7:0] stats [4];

  always_ff @(posedge clk) begin
    if (!hrst_n) begin
      for (int i = 0; i < 4; i++) stats[i] <= '0;
    end else if (coin_take && stats[coin] != 8'hFF) begin
      stats[coin] <= stats[coin] + 8'd1;
    end
  end

  assign coin_stats = {stats[3], stats[2], stats[1], stats[0]};
`else
  assign coin_stats = '0;
`endif

endmodule
